// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA test-pattern checker and generator.
// Timing defaults describe 640x480 at a 25 MHz pixel clock.
package vga_pkg;

  localparam int unsigned VGA_TOTAL_COLS  = 800;
  localparam int unsigned VGA_TOTAL_ROWS  = 525;
  localparam int unsigned VGA_ACTIVE_COLS = 640;
  localparam int unsigned VGA_ACTIVE_ROWS = 480;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned PAT_W = 3;

  localparam logic [PAT_W-1:0] PAT_OFF     = 3'd0;
  localparam logic [PAT_W-1:0] PAT_RED     = 3'd1;
  localparam logic [PAT_W-1:0] PAT_GREEN   = 3'd2;
  localparam logic [PAT_W-1:0] PAT_BLUE    = 3'd3;
  localparam logic [PAT_W-1:0] PAT_CHECKER = 3'd4;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } vga_state_e;

  // Codes above CHECKER carry no defined image and are never compared.
  function automatic logic pattern_is_checked(input logic [PAT_W-1:0] pat);
    return (pat <= PAT_CHECKER);
  endfunction

endpackage

// File: rtl/vga_pattern_checker_if.sv
// Video stream in, check status out, for the VGA pattern checker.
// master drives the stream and reads status; slave is the checker.
interface vga_pattern_checker_if
  import vga_pkg::*;
#(
  parameter int unsigned VIDEO_WIDTH = 3,
  parameter int unsigned ERR_WIDTH   = 20
);

  logic [PAT_W-1:0]       i_pattern;
  logic                   i_hsync;
  logic                   i_vsync;
  logic [VIDEO_WIDTH-1:0] i_red_video;
  logic [VIDEO_WIDTH-1:0] i_green_video;
  logic [VIDEO_WIDTH-1:0] i_blue_video;

  logic                   o_locked;
  logic                   o_frame_done;
  logic [ERR_WIDTH-1:0]   o_err_count;
  logic                   o_err_sticky;
  logic                   o_timing_err;
  logic [CNT_W-1:0]       o_col_count;
  logic [CNT_W-1:0]       o_row_count;

  modport master (
    output i_pattern, i_hsync, i_vsync, i_red_video, i_green_video, i_blue_video,
    input  o_locked, o_frame_done, o_err_count, o_err_sticky, o_timing_err,
           o_col_count, o_row_count
  );

  modport slave (
    input  i_pattern, i_hsync, i_vsync, i_red_video, i_green_video, i_blue_video,
    output o_locked, o_frame_done, o_err_count, o_err_sticky, o_timing_err,
           o_col_count, o_row_count
  );

endinterface

// File: rtl/vga_expected_pixel.sv
// Expected RGB for a (pattern, col, row) position plus a flag saying whether
// that pixel is compared at all. Purely combinational; shared with the generator.
module vga_expected_pixel
  import vga_pkg::*;
#(
  parameter int unsigned VIDEO_WIDTH = 3,
  parameter int unsigned ACTIVE_COLS = VGA_ACTIVE_COLS,
  parameter int unsigned ACTIVE_ROWS = VGA_ACTIVE_ROWS
) (
  input  logic [PAT_W-1:0]       i_pattern,
  input  logic [CNT_W-1:0]       i_col,
  input  logic [CNT_W-1:0]       i_row,
  output logic [VIDEO_WIDTH-1:0] o_red_c,
  output logic [VIDEO_WIDTH-1:0] o_green_c,
  output logic [VIDEO_WIDTH-1:0] o_blue_c,
  output logic                   o_check_en_c
);

  localparam logic [VIDEO_WIDTH-1:0] ONES = {VIDEO_WIDTH{1'b1}};

  logic active_c;

  always_comb begin
    o_red_c      = '0;
    o_green_c    = '0;
    o_blue_c     = '0;
    active_c     = (i_col < CNT_W'(ACTIVE_COLS)) && (i_row < CNT_W'(ACTIVE_ROWS));
    o_check_en_c = active_c && pattern_is_checked(i_pattern);
    case (i_pattern)
      PAT_RED:     o_red_c   = ONES;
      PAT_GREEN:   o_green_c = ONES;
      PAT_BLUE:    o_blue_c  = ONES;
      PAT_CHECKER: begin
        // 32x32 checkerboard
        if (i_col[5] ^ i_row[5]) begin
          o_red_c   = ONES;
          o_green_c = ONES;
          o_blue_c  = ONES;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vga_pattern_checker.sv
// Receive-side test-pattern checker: recovers position from hsync/vsync,
// locks onto compliant timing and counts per-frame pixel mismatches.
module vga_pattern_checker
  import vga_pkg::*;
#(
  parameter int unsigned VIDEO_WIDTH = 3,
  parameter int unsigned TOTAL_COLS  = VGA_TOTAL_COLS,
  parameter int unsigned TOTAL_ROWS  = VGA_TOTAL_ROWS,
  parameter int unsigned ACTIVE_COLS = VGA_ACTIVE_COLS,
  parameter int unsigned ACTIVE_ROWS = VGA_ACTIVE_ROWS,
  parameter logic        SYNC_POL    = 1'b0,
  parameter int unsigned ERR_WIDTH   = 20
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  vga_pattern_checker_if.slave  vif
);

  localparam logic [CNT_W-1:0]     LAST_COL = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0]     LAST_ROW = CNT_W'(TOTAL_ROWS - 1);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX  = {ERR_WIDTH{1'b1}};

  vga_state_e             state_q, state_d;
  logic                   hs_q, hs_d;
  logic                   vs_q, vs_d;
  logic [CNT_W-1:0]       col_q, col_d;
  logic [CNT_W-1:0]       row_q, row_d;
  logic [PAT_W-1:0]       pat_q, pat_d;
  logic                   frame_bad_q, frame_bad_d;
  logic [ERR_WIDTH-1:0]   acc_q, acc_d;
  logic [ERR_WIDTH-1:0]   err_count_q, err_count_d;
  logic                   locked_q, locked_d;
  logic                   frame_done_q, frame_done_d;
  logic                   err_sticky_q, err_sticky_d;
  logic                   timing_err_q, timing_err_d;

  logic                   hs_edge_c, vs_edge_c;
  logic                   sync_viol_c, viol_c;
  logic [CNT_W-1:0]       cnt_col_c, cnt_row_c;
  logic                   frame_end_c;
  logic                   mismatch_c;
  logic [ERR_WIDTH-1:0]   acc_base_c;
  logic [VIDEO_WIDTH-1:0] exp_red_c, exp_green_c, exp_blue_c;
  logic                   check_en_c;

  // Leading-edge detect and free-running position with timing checks against pre-update counters.
  always_comb begin
    hs_d        = vif.i_hsync;
    vs_d        = vif.i_vsync;
    hs_edge_c   = (hs_q != SYNC_POL) && (vif.i_hsync == SYNC_POL);
    vs_edge_c   = (vs_q != SYNC_POL) && (vif.i_vsync == SYNC_POL);
    cnt_col_c   = col_q + CNT_W'(1);
    cnt_row_c   = row_q;
    sync_viol_c = 1'b0;
    if (vs_edge_c) begin
      cnt_col_c   = '0;
      cnt_row_c   = '0;
      sync_viol_c = (col_q != LAST_COL) || (row_q != LAST_ROW);
    end else if (hs_edge_c) begin
      cnt_col_c   = '0;
      cnt_row_c   = row_q + CNT_W'(1);
      sync_viol_c = (col_q != LAST_COL) || (row_q == LAST_ROW);
    end else if (col_q == LAST_COL) begin
      // hsync never came: wrap anyway so position stays sane
      cnt_col_c   = '0;
      cnt_row_c   = row_q + CNT_W'(1);
      sync_viol_c = 1'b1;
    end
    viol_c = sync_viol_c && (state_q != ST_UNLOCKED);
    pat_d  = vs_edge_c ? vif.i_pattern : pat_q;
  end

  vga_expected_pixel #(
    .VIDEO_WIDTH (VIDEO_WIDTH),
    .ACTIVE_COLS (ACTIVE_COLS),
    .ACTIVE_ROWS (ACTIVE_ROWS)
  ) u_expected (
    .i_pattern    (pat_d),
    .i_col        (cnt_col_c),
    .i_row        (cnt_row_c),
    .o_red_c      (exp_red_c),
    .o_green_c    (exp_green_c),
    .o_blue_c     (exp_blue_c),
    .o_check_en_c (check_en_c)
  );

  assign mismatch_c = check_en_c &&
                      ((vif.i_red_video   != exp_red_c)   ||
                       (vif.i_green_video != exp_green_c) ||
                       (vif.i_blue_video  != exp_blue_c));

  // Lock FSM next state and registered-output next values.
  always_comb begin
    state_d      = state_q;
    frame_bad_d  = frame_bad_q;
    frame_end_c  = 1'b0;
    timing_err_d = 1'b0;
    case (state_q)
      ST_UNLOCKED: begin
        if (vs_edge_c) begin
          state_d     = ST_ACQUIRE;
          frame_bad_d = 1'b0;
        end
      end
      ST_ACQUIRE: begin
        if (vs_edge_c) begin
          frame_bad_d = 1'b0;
          if (!frame_bad_q && !viol_c) begin
            state_d = ST_LOCKED;
          end
        end else begin
          frame_bad_d = frame_bad_q | viol_c;
        end
      end
      ST_LOCKED: begin
        if (viol_c) begin
          state_d      = ST_UNLOCKED;
          timing_err_d = 1'b1;
        end else if (vs_edge_c) begin
          frame_end_c = 1'b1;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase

    col_d        = (state_d == ST_UNLOCKED) ? '0 : cnt_col_c;
    row_d        = (state_d == ST_UNLOCKED) ? '0 : cnt_row_c;
    locked_d     = (state_d == ST_LOCKED);
    frame_done_d = frame_end_c;
    err_count_d  = frame_end_c ? acc_q : err_count_q;
    err_sticky_d = err_sticky_q | (frame_end_c && (acc_q != '0));

    // The edge-cycle pixel opens the next frame's tally.
    acc_base_c = frame_end_c ? '0 : acc_q;
    acc_d      = acc_base_c;
    if (state_d != ST_LOCKED) begin
      acc_d = '0;
    end else if (mismatch_c && (acc_base_c != ERR_MAX)) begin
      acc_d = acc_base_c + ERR_WIDTH'(1);
    end
  end

  // Sync samples reset to the asserted level so a sync already active at release is not an edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_UNLOCKED;
      hs_q         <= SYNC_POL;
      vs_q         <= SYNC_POL;
      col_q        <= '0;
      row_q        <= '0;
      pat_q        <= '0;
      frame_bad_q  <= 1'b0;
      acc_q        <= '0;
      err_count_q  <= '0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      err_sticky_q <= 1'b0;
      timing_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pat_q        <= pat_d;
      frame_bad_q  <= frame_bad_d;
      acc_q        <= acc_d;
      err_count_q  <= err_count_d;
      locked_q     <= locked_d;
      frame_done_q <= frame_done_d;
      err_sticky_q <= err_sticky_d;
      timing_err_q <= timing_err_d;
    end
  end

  assign vif.o_locked     = locked_q;
  assign vif.o_frame_done = frame_done_q;
  assign vif.o_err_count  = err_count_q;
  assign vif.o_err_sticky = err_sticky_q;
  assign vif.o_timing_err = timing_err_q;
  assign vif.o_col_count  = col_q;
  assign vif.o_row_count  = row_q;

endmodule
